bp_update_sched: RTL
====================

# bp_update_sched

Sequences all writes into the branch-predictor tables (BHT/BTB) from branch-resolution results. It sits between the execute-stage branch resolution output and the predictor's single shared write port. It clears the tables after reset or flush, then buffers resolved branches in an in-order FIFO and drains them through a valid/ready write port. Branch resolution never stalls; overflow drops updates.

## Interface
- NR_ROWS, 8: predictor rows; power of two, ≥2
- DEPTH, 4: FIFO entries; power of two, ≥2
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  clear tables and discard queued updates
- res_valid_i  in  1  resolved branch valid
- res_pc_i  in  64  PC of resolved instruction
- res_target_i  in  64  resolved target address
- res_taken_i  in  1  branch outcome
- res_mispredict_i  in  1  misprediction flag
- res_cf_i  in  ariane_pkg::cf_t  control-flow type
- upd_ready_i  in  1  predictor accepts write this cycle
- upd_valid_o  out  1  write request
- upd_clear_o  out  1  write is a row clear (INIT)
- upd_index_o  out  $clog2(NR_ROWS)  row index
- upd_pc_o, upd_target_o  out  64 each  entry fields
- upd_taken_o  out  1  entry outcome
- upd_cf_o  out  ariane_pkg::cf_t  entry type
- busy_o  out  1  RST or INIT in progress
- full_o  out  1  FIFO holds DEPTH entries
- drop_cnt_o  out  16  dropped-update counter

## Operation
- FSM RST → INIT → RUN. Reset enters RST. RST → INIT unconditionally next cycle. INIT → RUN after the clear write for row NR_ROWS-1 handshakes. flush_i in any state → INIT with row counter 0; flush wins over all other events.
- INIT: upd_valid_o=1, upd_clear_o=1, upd_index_o=row counter. Counter advances only on upd_ready_i. Other upd_* fields are 0.
- Enqueue condition: res_valid_i && (res_cf_i==Branch || (res_mispredict_i && res_cf_i==JumpR)). Return, Jump, and NoCF are never enqueued.
- Enqueue is allowed in RST/INIT/RUN. It is blocked only by flush_i or a full FIFO.
- RUN: upd_valid_o = FIFO non-empty. Fields come from the head entry. upd_index_o = head pc[1 +: $clog2(NR_ROWS)]. upd_clear_o=0. Pop on upd_valid_o && upd_ready_i.
- Full rule: an enqueue is accepted if count<DEPTH, or count==DEPTH with a pop in the same cycle. Otherwise the incoming update is dropped and drop_cnt_o increments.
- drop_cnt_o saturates at 16'hFFFF and is cleared only by reset.
- flush_i empties the FIFO. A res_valid_i arriving in the flush cycle is discarded and not counted as a drop.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.

## Timing
- Reset values: upd_valid_o=0, upd_clear_o=0, upd_index_o=0, all upd_* fields 0, busy_o=1, full_o=0, drop_cnt_o=0, FIFO empty.
- First clear request appears 1 cycle after reset deassertion. With upd_ready_i held high, INIT takes NR_ROWS cycles.
- FIFO is registered. An entry enqueued at edge N is presented on upd_valid_o no earlier than after edge N (next cycle), only once in RUN.
- Outputs are stable while upd_valid_o && !upd_ready_i.
- busy_o and full_o derive from registered state; no combinational path from res_* to upd_*.
- Reset asserted mid-INIT or mid-drain clears everything asynchronously. Restart goes via RST.

## Configuration
- BP_UPD_DROP_CNT_EN defined: the drop counter is implemented as above.
- BP_UPD_DROP_CNT_EN undefined: no counter flops; drop_cnt_o tied to 0. Drop behaviour is otherwise identical.

## Test plan
- Reset, upd_ready_i=1, NR_ROWS=8 → RST 1 cycle, clear writes index 0..7 on consecutive cycles, then busy_o=0 and upd_valid_o=0.
- RUN, resolve Branch pc=0x8000_0010 taken target 0x8000_0100 → next cycle upd_valid_o=1, upd_index_o=0 (pc[3:1]), taken=1, cf=Branch.
- Resolve JumpR with mispredict=0, then JumpR with mispredict=1, then Return with mispredict=1 → exactly one entry (the second) is output.
- upd_ready_i=0, 6 consecutive Branch resolves, DEPTH=4 → full_o=1 after 4, drop_cnt_o=2 (0 with macro off). Release ready → 4 entries drain in order.
- FIFO holding 3 entries, flush_i together with a res_valid_i → FIFO empties, INIT restarts at index 0, drop_cnt_o unchanged.
- Full FIFO with pop and push in the same cycle → push accepted, count stays 4, no drop.

Source files
------------

// File: rtl/bp_update_sched.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_sched (plus the ariane_pkg control-flow type it uses)
//  Purpose  : Owns the branch-predictor (BHT/BTB) shared write port. It clears
//             every predictor row after reset or flush. It then buffers
//             resolved branches in an in-order FIFO and drains them through a
//             valid/ready write port. Resolution is never back-pressured; an
//             update arriving at a full FIFO is dropped and counted.
//  Ports    : clk_i, rst_ni (async, active low), flush_i
//             res_*  : branch-resolution input (valid, pc, target, taken,
//                      mispredict, cf)
//             upd_*  : predictor write port (valid/ready, clear, index, pc,
//                      target, taken, cf)
//             busy_o : reset/clear sequence in progress
//             full_o : FIFO holds DEPTH entries
//             drop_cnt_o : saturating dropped-update counter
//  Config   : BP_UPD_DROP_CNT_EN - when defined, drop_cnt_o is a real counter;
//             otherwise it is tied to zero and no counter flops exist.
//  Revision : 1.0 - initial release
// ============================================================================

package ariane_pkg;
    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;
endpackage

module bp_update_sched #(
    parameter int unsigned NR_ROWS = 8,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       res_valid_i,
    input  logic [63:0]                res_pc_i,
    input  logic [63:0]                res_target_i,
    input  logic                       res_taken_i,
    input  logic                       res_mispredict_i,
    input  ariane_pkg::cf_t            res_cf_i,
    input  logic                       upd_ready_i,
    output logic                       upd_valid_o,
    output logic                       upd_clear_o,
    output logic [$clog2(NR_ROWS)-1:0] upd_index_o,
    output logic [63:0]                upd_pc_o,
    output logic [63:0]                upd_target_o,
    output logic                       upd_taken_o,
    output ariane_pkg::cf_t            upd_cf_o,
    output logic                       busy_o,
    output logic                       full_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned c_IDX_W = $clog2(NR_ROWS);
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_IDX_W-1:0]   r_row;
    logic [c_IDX_W-1:0]   w_row_nxt;

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    logic [63:0]          r_pc     [DEPTH];
    logic [63:0]          r_target [DEPTH];
    logic                 r_taken  [DEPTH];
    ariane_pkg::cf_t      r_cf     [DEPTH];

    logic                 w_enq_req;
    logic                 w_not_empty;
    logic                 w_pop;
    logic                 w_push;

    // Only conditional branches and mispredicted indirect jumps train the
    // predictor; returns and direct jumps are predicted elsewhere.
    assign w_enq_req   = res_valid_i &&
                         ((res_cf_i == ariane_pkg::Branch) ||
                          (res_mispredict_i && (res_cf_i == ariane_pkg::JumpR)));
    assign w_not_empty = (r_count != '0);
    assign w_pop       = (r_state == ST_RUN) && w_not_empty && upd_ready_i;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_push      = w_enq_req && !flush_i &&
                         ((r_count < c_CNT_W'(DEPTH)) || w_pop);

    assign busy_o = (r_state != ST_RUN);
    assign full_o = (r_count == c_CNT_W'(DEPTH));

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RST;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and write-port outputs (outputs depend on state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        upd_valid_o  = 1'b0;
        upd_clear_o  = 1'b0;
        upd_index_o  = '0;
        upd_pc_o     = '0;
        upd_target_o = '0;
        upd_taken_o  = 1'b0;
        upd_cf_o     = ariane_pkg::NoCF;

        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_INIT;
                w_row_nxt   = '0;
            end
            ST_INIT: begin
                upd_valid_o = 1'b1;
                upd_clear_o = 1'b1;
                upd_index_o = r_row;
                if (upd_ready_i) begin
                    if (r_row == c_IDX_W'(NR_ROWS - 1)) begin
                        w_state_nxt = ST_RUN;
                        w_row_nxt   = '0;
                    end else begin
                        w_row_nxt = r_row + c_IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (w_not_empty) begin
                    upd_valid_o  = 1'b1;
                    // Bit 0 is dropped: compressed instructions are halfword aligned.
                    upd_index_o  = r_pc[r_rd_ptr][1 +: c_IDX_W];
                    upd_pc_o     = r_pc[r_rd_ptr];
                    upd_target_o = r_target[r_rd_ptr];
                    upd_taken_o  = r_taken[r_rd_ptr];
                    upd_cf_o     = r_cf[r_rd_ptr];
                end
            end
            default: begin
                w_state_nxt = ST_RST;
                w_row_nxt   = '0;
            end
        endcase

        // Flush overrides every other transition and restarts the clear walk.
        if (flush_i) begin
            w_state_nxt = ST_INIT;
            w_row_nxt   = '0;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed when count != 0.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc[r_wr_ptr]     <= res_pc_i;
            r_target[r_wr_ptr] <= res_target_i;
            r_taken[r_wr_ptr]  <= res_taken_i;
            r_cf[r_wr_ptr]     <= res_cf_i;
        end
    end

    // ------------------------------------------------------------------
    // Dropped-update counter
    // ------------------------------------------------------------------
`ifdef BP_UPD_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // Updates discarded by a flush are intentional, not overflow drops.
    assign w_drop = w_enq_req && !flush_i && !w_push;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

`default_nettype wire
